mlp_neuron_accum: RTL and testbench

- Consumes the signed 44-bit product stream of the 16s×28s multiply stage in the MLP datapath.
- Accumulates one neuron's dot product, adds bias, then rounds, shifts, applies ReLU and saturates to a 16-bit activation.
- Owns the multiplier's ce: carries valid/last tags through a delay line matched to the multiplier pipeline, and stalls multiplier and upstream issue on output back-pressure.

---
 rtl/mlp_neuron_accum.sv | 141 ++++++++++++++
 tb/tb_mlp_neuron_accum.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_neuron_accum.sv
// MLP neuron accumulator: sums a product stream, adds bias, then
// rounds, shifts, applies ReLU and saturates one activation per neuron.
module mlp_neuron_accum #(
    parameter int PROD_WIDTH  = 44,
    parameter int ACC_WIDTH   = 52,
    parameter int BIAS_WIDTH  = 28,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 12,
    parameter int MUL_LATENCY = 3,
    parameter int RELU_EN     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mul_ce,
    input  logic [PROD_WIDTH-1:0] prod,
    input  logic [BIAS_WIDTH-1:0] bias,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int TW = ACC_WIDTH + 2;

    localparam logic signed [TW-1:0] OMAX =
        (TW'(1) << (OUT_WIDTH - 1)) - TW'(1);
    localparam logic signed [TW-1:0] OMIN = ~OMAX;
    localparam logic signed [TW-1:0] RND  = TW'(1) << (SHIFT - 1);

    logic                        ce;
    logic [MUL_LATENCY-1:0]      tag_v;
    logic [MUL_LATENCY-1:0]      tag_l;
    logic                        tail_v;
    logic                        tail_l;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] fin;
    logic signed [ACC_WIDTH-1:0] prod_x;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [BIAS_WIDTH-1:0]       bias_q;
    logic                        fin_valid;

    logic signed [TW-1:0]        fin_x;
    logic signed [TW-1:0]        bias_x;
    logic signed [TW-1:0]        t;
    logic signed [TW-1:0]        r;
    logic signed [TW-1:0]        rr;
    logic [OUT_WIDTH-1:0]        data_n;
    logic                        sat_n;

    // Everything advances together unless a held result blocks the output.
    // out_valid is cleared asynchronously, so ce is 1 throughout reset.
    assign ce       = !(out_valid && !out_ready);
    assign mul_ce   = ce;
    assign in_ready = ce;

    assign tail_v = tag_v[MUL_LATENCY-1];
    assign tail_l = tag_l[MUL_LATENCY-1];

    assign prod_x = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign sum    = acc + prod_x;

    // Tag delay line tracking the multiplier pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            tag_l <= '0;
        end else if (ce) begin
            tag_v[0] <= in_valid && in_ready;
            tag_l[0] <= in_valid && in_last;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    // Accumulate terms; the last term hands the total to the finish stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            fin       <= '0;
            bias_q    <= '0;
            fin_valid <= 1'b0;
        end else if (ce) begin
            fin_valid <= tail_v && tail_l;
            if (tail_v) begin
                if (tail_l) begin
                    fin    <= sum;
                    bias_q <= bias;
                    acc    <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    assign fin_x  = {{(TW-ACC_WIDTH){fin[ACC_WIDTH-1]}}, fin};
    assign bias_x = {{(TW-BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};
    assign t      = fin_x + bias_x + RND;
    assign r      = t >>> SHIFT;

    // Round/shift result through optional ReLU and output saturation.
    always_comb begin
        rr     = r;
        sat_n  = 1'b0;
        data_n = r[OUT_WIDTH-1:0];
        if (RELU_EN != 0 && r < 0) begin
            rr = '0;
        end
        if (rr > OMAX) begin
            data_n = OMAX[OUT_WIDTH-1:0];
            sat_n  = 1'b1;
        end else if (rr < OMIN) begin
            data_n = OMIN[OUT_WIDTH-1:0];
            sat_n  = 1'b1;
        end else begin
            data_n = rr[OUT_WIDTH-1:0];
        end
    end

    // Output register: hold under back-pressure, reload on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce && fin_valid) begin
            out_data  <= data_n;
            out_sat   <= sat_n;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mlp_neuron_accum.sv
// Bench for mlp_neuron_accum: behavioural multiplier, golden model,
// scoreboard queues for a ReLU instance and a linear instance.
module tb_mlp_neuron_accum;

    localparam int PW  = 44;
    localparam int AW  = 52;
    localparam int BW  = 28;
    localparam int OW  = 16;
    localparam int SH  = 12;
    localparam int ML  = 3;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic [BW-1:0] bias = '0;

    logic signed [15:0] a = '0;
    logic signed [27:0] b = '0;
    logic signed [PW-1:0] m0 = '0;
    logic signed [PW-1:0] m1 = '0;
    logic signed [PW-1:0] m2 = '0;

    logic ir0, ce0, os0, ov0;
    logic ir1, ce1, os1, ov1;
    logic [OW-1:0] od0, od1;

    exp_t q0[$];
    exp_t q1[$];
    longint model_sum = 0;
    longint cur_bias = 0;
    int checks = 0;
    int passed = 0;
    int n_push = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    // Behavioural 3-stage multiplier gated by the DUT's clock enable.
    always @(posedge clk) begin
        if (ce0) begin
            m0 <= a * b;
            m1 <= m0;
            m2 <= m1;
        end
    end

    mlp_neuron_accum #(
        .PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
        .OUT_WIDTH(OW), .SHIFT(SH), .MUL_LATENCY(ML), .RELU_EN(1)
    ) u_relu (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir0), .mul_ce(ce0),
        .prod(m2), .bias(bias), .out_data(od0), .out_sat(os0),
        .out_valid(ov0), .out_ready(out_ready)
    );

    mlp_neuron_accum #(
        .PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
        .OUT_WIDTH(OW), .SHIFT(SH), .MUL_LATENCY(ML), .RELU_EN(0)
    ) u_lin (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir1), .mul_ce(ce1),
        .prod(m2), .bias(bias), .out_data(od1), .out_sat(os1),
        .out_valid(ov1), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void golden(input longint s, input longint bs,
                                   input bit relu, output longint d,
                                   output bit sat);
        longint t;
        longint r;
        t = ((s <<< (64 - AW)) >>> (64 - AW)) + bs + (64'sd1 <<< (SH - 1));
        r = t >>> SH;
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > 32767) begin
            r = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat = 1'b1;
        end
        d = r;
    endfunction

    task automatic set_bias(input longint v);
        cur_bias = v;
        bias = BW'(v);
    endtask

    task automatic issue(input longint av, input longint bv, input bit last);
        int g;
        exp_t e;
        @(negedge clk);
        a = 16'(av);
        b = 28'(bv);
        in_valid = 1'b1;
        in_last = last;
        g = 0;
        while (!ir0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("issue_timeout", g, 0);
        @(posedge clk);
        model_sum += av * bv;
        if (last) begin
            golden(model_sum, cur_bias, 1'b1, e.d, e.s);
            q0.push_back(e);
            golden(model_sum, cur_bias, 1'b0, e.d, e.s);
            q1.push_back(e);
            n_push++;
            model_sum = 0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q0.size() != 0 || ov0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", q0.size(), 0);
    endtask

    task automatic wait_ov();
        int g;
        g = 0;
        while (!ov0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("wait_ov", ov0, 1);
    endtask

    // Scoreboard: compare each accepted result against the queue head.
    always @(negedge clk) begin
        if (!reset && ov0 && out_ready) begin
            exp_t e0;
            exp_t e1;
            n_out++;
            chk("ov_lin", ov1, ov0);
            if (q0.size() == 0 || q1.size() == 0) begin
                chk("extra_output", 1, 0);
            end else begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("data_relu", $signed(od0), e0.d);
                chk("sat_relu", os0, e0.s);
                chk("data_lin", $signed(od1), e1.d);
                chk("sat_lin", os1, e1.s);
            end
        end
    end

    initial begin
        int k;
        #1;
        chk("rst_ov", ov0, 0);
        chk("rst_data", od0, 0);
        chk("rst_sat", os0, 0);
        chk("rst_ce", ce0, 1);
        chk("rst_ir", ir0, 1);
        chk("rst_ov_lin", ov1, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        set_bias(2048);
        issue(2, 4096, 1'b0);
        issue(3, 4096, 1'b1);
        idle();
        k = 1;
        while (!ov0 && k < 20) begin
            @(posedge clk);
            #1;
            if (!ov0) k++;
        end
        chk("latency_edges", k + 1, ML + 2);
        drain();

        set_bias(0);
        issue(-5, 4096, 1'b1);
        idle();
        drain();

        issue(32767, 1 << 26, 1'b1);
        issue(-32768, 1 << 26, 1'b1);
        idle();
        drain();

        out_ready = 1'b0;
        issue(1, 4096, 1'b1);
        issue(2, 4096, 1'b1);
        idle();
        wait_ov();
        for (int i = 0; i < 4; i++) begin
            chk("hold_data", od0, 1);
            chk("hold_ce", ce0, 0);
            chk("hold_ir", ir0, 0);
            chk("hold_ce_lin", ce1, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        issue(3, 4096, 1'b1);
        issue(1, 4096, 1'b0);
        issue(1, 4096, 1'b0);
        idle();
        wait_ov();
        #2;
        reset = 1'b1;
        #1;
        chk("async_ov", ov0, 0);
        chk("async_ov_lin", ov1, 0);
        chk("async_data", od0, 0);
        chk("async_ce", ce0, 1);
        chk("async_ir", ir0, 1);
        n_push -= q0.size();
        q0.delete();
        q1.delete();
        model_sum = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        issue(7, 4096, 1'b1);
        idle();
        drain();

        for (int i = 0; i < 256; i++) begin
            issue(-32768, -(64'sd1 <<< 27) + 1, i == 255);
        end
        idle();
        drain();

        repeat (10) @(negedge clk);
        chk("out_count", n_out, n_push);
        chk("q_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
